m_seg7_scan: RTL

M_SEG7_SCAN -- requirements
Module: m_seg7_scan

---
 rtl/m_seg7_scan_pkg.sv | 14 +
 rtl/m_seg7_scan_dec.sv | 9 +
 rtl/m_seg7_scan.sv | 81 ++++++++
 3 files changed

// File: rtl/m_seg7_scan_pkg.sv
// m_seg7_scan_pkg: shared constants for the seven-segment scan display
package m_seg7_scan_pkg;
  localparam int SCAN_CYCLES_DEF = 100000;
  localparam int BLANK_CYCLES_DEF = 1000;
  localparam int DIG_W = 2;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // active-low {g,f,e,d,c,b,a}; index 0 is the rightmost entry
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/m_seg7_scan_dec.sv
// m_seg7_dec: hex nibble to active-low seven-segment pattern
module m_seg7_dec
  import m_seg7_scan_pkg::*;
(
  input  logic [3:0] w_hex,
  output logic [6:0] w_seg
);
  assign w_seg = SEG_HEX[w_hex];
endmodule

// File: rtl/m_seg7_scan.sv
// m_seg7_scan: four-digit multiplexed display of a value and its BCD change count
module m_seg7_scan
  import m_seg7_scan_pkg::*;
#(
  parameter int SCAN_CYCLES = SCAN_CYCLES_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic       w_clk,
  input  logic       w_rst_n,
  input  logic [3:0] w_val,
  output logic [6:0] w_seg,
  output logic       w_dp,
  output logic [3:0] w_an
);
  localparam int CW = $clog2(SCAN_CYCLES);
  logic [CW-1:0] r_cnt;
  logic [DIG_W-1:0] r_dig;
  logic [3:0] r_val, r_ones, r_tens;
  logic [3:0] r_snap_val, r_snap_ones, r_snap_tens;
  logic term, frame, chg, blank;
  logic [3:0] dig_hex, an_nxt;
  logic [6:0] dec_seg;
  assign term = r_cnt == CW'(SCAN_CYCLES - 1);
  assign frame = term && r_dig == 2'd3;
  assign chg = w_val != r_val;
  assign dig_hex = r_dig == 2'd0 ? r_snap_val : r_dig == 2'd1 ? r_snap_ones : r_snap_tens;
  assign blank = r_dig == 2'd3 || (r_dig == 2'd2 && r_snap_tens == 4'd0);
  assign an_nxt = r_cnt < CW'(BLANK_CYCLES) ? 4'hF : ~(4'b0001 << r_dig);
  m_seg7_dec u_dec (
    .w_hex(dig_hex),
    .w_seg(dec_seg)
  );
  // slot counter and digit index
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_cnt <= '0;
      r_dig <= '0;
    end else begin
      r_cnt <= term ? '0 : r_cnt + CW'(1);
      r_dig <= term ? r_dig + 2'd1 : r_dig;
    end
  end
  // input register and two-digit BCD change count
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_val <= '0;
      r_ones <= '0;
      r_tens <= '0;
    end else begin
      r_val <= w_val;
      if (chg) begin
        r_ones <= r_ones == 4'd9 ? 4'd0 : r_ones + 4'd1;
        if (r_ones == 4'd9) r_tens <= r_tens == 4'd9 ? 4'd0 : r_tens + 4'd1;
      end
    end
  end
  // display snapshot, refreshed only at the frame boundary from pre-increment state
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_snap_val <= '0;
      r_snap_ones <= '0;
      r_snap_tens <= '0;
    end else if (frame) begin
      r_snap_val <= r_val;
      r_snap_ones <= r_ones;
      r_snap_tens <= r_tens;
    end
  end
  // registered display outputs, one cycle behind the scan position
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      w_an <= 4'hF;
      w_seg <= SEG_BLANK;
      w_dp <= 1'b1;
    end else begin
      w_an <= an_nxt;
      w_seg <= blank ? SEG_BLANK : dec_seg;
      w_dp <= an_nxt[1];
    end
  end
endmodule
